// File: rtl/bk_pkg.sv
// bk_pkg: shared types and sizing helpers for the nibble-serial adder
package bk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int NIBBLE_W = 4;

    function automatic int idx_w(input int nibbles);
        return (nibbles <= 2) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/brent_kung_cin.sv
// brent_kung_cin: 4-bit Brent-Kung prefix adder with carry-in, out = {cout, sum}
module brent_kung_cin (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [4:0] out_o
);

    logic [3:0] g, p;
    logic       g10, p10, g32, p32, g20, p20, g30, p30;
    logic [4:0] c;

    assign g   = a_i & b_i;
    assign p   = a_i ^ b_i;
    assign g10 = g[1] | (p[1] & g[0]);
    assign p10 = p[1] & p[0];
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g30 = g32 | (p32 & g10);
    assign p30 = p32 & p10;
    assign g20 = g[2] | (p[2] & g10);
    assign p20 = p[2] & p10;
    assign c   = {g30 | (p30 & cin_i), g20 | (p20 & cin_i), g10 | (p10 & cin_i), g[0] | (p[0] & cin_i), cin_i};
    assign out_o = {c[4], p ^ c[3:0]};

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit adder that reuses one 4-bit adder over NIBBLES cycles
module nibble_serial_adder
    import bk_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int IW = idx_w(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                carry_q, carry_d;
    logic [NIBBLE_W:0]   add_out;
    logic                accept;

    brent_kung_cin u_add (
        .a_i   (a_q[{idx_q, 2'b00} +: NIBBLE_W]),
        .b_i   (b_q[{idx_q, 2'b00} +: NIBBLE_W]),
        .cin_i (carry_q),
        .out_o (add_out)
    );

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready && ena;
    assign out_valid = state_q == DONE;
    assign busy      = state_q == RUN;
    assign sum       = sum_q;
    assign cout      = carry_q;

    // Next state: one nibble per enabled RUN cycle; accept overrides a completing handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        if (ena && state_q == RUN) begin
            sum_d[{idx_q, 2'b00} +: NIBBLE_W] = add_out[NIBBLE_W-1:0];
            carry_d = add_out[NIBBLE_W];
            idx_d   = idx_q + 1'b1;
            state_d = (idx_q == LAST) ? DONE : RUN;
        end else if (ena && state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
            sum_d   = '0;
            state_d = RUN;
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed tests plus a cycle-level reference model
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int total = 0;
    int bad = 0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: a transaction takes N enabled cycles, then waits for consumption
    int       m_cnt = 0;
    logic     m_has = 1'b0;
    logic [W:0] m_res = '0;
    logic [W:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        logic rdy, acc;
        if (!rst_n) begin
            m_cnt = 0;
            m_has = 1'b0;
            m_res = '0;
        end else if (ena) begin
            rdy = (m_cnt == 0 && !m_has) || (m_has && out_ready);
            acc = in_valid && rdy;
            if (m_has && out_ready) m_has = 1'b0;
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_has = 1'b1;
                    m_res = m_pend;
                end
            end
            if (acc) begin
                m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_cnt  = N;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("mdl_out_valid", 32'(out_valid), 32'(m_has));
            check("mdl_busy", 32'(busy), 32'(m_cnt > 0));
            check("mdl_in_ready", 32'(in_ready), 32'((m_cnt == 0 && !m_has) || (m_has && out_ready)));
            if (m_has) check("mdl_result", 32'({cout, sum}), 32'(m_res));
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        logic ok;
        ok = 1'b0;
        a = ta;
        b = tb_v;
        cin = tc;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready && ena) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("issue_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic take(output logic [W:0] r);
        r = {cout, sum};
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat, lat2;
        logic [W:0] r;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_done(lat);
        check("ripple_latency", 32'(lat), 32'(4));
        take(r);
        check("ripple_result", 32'(r), 32'h1_0000);

        issue(16'h1234, 16'h4321, 1'b1);
        wait_done(lat);
        take(r);
        check("cin_result", 32'(r), 32'h0_5556);

        out_ready = 1'b1;
        issue(16'h00FF, 16'h0001, 1'b0);
        wait_done(lat);
        check("b2b_first", 32'({cout, sum}), 32'h0_0100);
        issue(16'h8000, 16'h8000, 1'b0);
        check("b2b_no_idle", 32'(busy), 32'(1));
        wait_done(lat);
        check("b2b_latency", 32'(lat), 32'(4));
        check("b2b_second", 32'({cout, sum}), 32'h1_0000);
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        issue(16'h0F0F, 16'h00F1, 1'b0);
        wait_done(lat);
        a = 16'h1111;
        b = 16'h2222;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_sum", 32'({cout, sum}), 32'h0_1000);
            check("bp_in_ready", 32'(in_ready), 32'(0));
            check("bp_valid", 32'(out_valid), 32'(1));
            check("bp_no_accept", 32'(busy), 32'(0));
        end
        out_ready = 1'b1;
        issue(16'h1111, 16'h2222, 1'b0);
        out_ready = 1'b0;
        wait_done(lat);
        take(r);
        check("bp_next_result", 32'(r), 32'h0_3333);

        issue(16'h1234, 16'h4321, 1'b1);
        lat = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ena = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall_frozen_busy", 32'(busy), 32'(1));
        ena = 1'b1;
        wait_done(lat2);
        check("stall_latency", 32'(lat + lat2), 32'(7));
        take(r);
        check("stall_result", 32'(r), 32'h0_5556);

        issue(16'hAAAA, 16'h5555, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'(1));
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_sum", 32'(sum), 32'(0));
        check("arst_cout", 32'(cout), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(16'h0001, 16'h0001, 1'b0);
        wait_done(lat);
        check("post_rst_latency", 32'(lat), 32'(4));
        take(r);
        check("post_rst_result", 32'(r), 32'h0_0002);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that time-multiplexes the existing 4-bit Brent-Kung carry-in adder (`brent_kung_cin`) across NIBBLES nibbles. It latches two W-bit operands and feeds them one nibble per cycle, LSB first, into the 4-bit adder. It chains the adder's carry-out through a register and collects the 4-bit partial sums into a W-bit result. It sits directly around the 4-bit adder, acting both as its operand source and its result consumer, behind a valid/ready request and response handshake.

## Interface
- NIBBLES, default 4: number of nibbles; W = 4*NIBBLES; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  clock enable; low freezes all state, and outputs hold.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry into nibble 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  W  result bits.
- cout  out  1  carry out of the top nibble.
- busy  out  1  high in the RUN state.

## Operation
- States:
  - IDLE: reset state.
  - RUN: nibble processing.
  - DONE: result held.
- Accept: `in_valid && in_ready && ena` latches a, b, and cin into the carry register. Also clears the index register and the sum register; next state is RUN.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). This allows a back-to-back accept on the same edge that the previous result is consumed.
- RUN, each enabled cycle:
  - Adder inputs: A nibble[idx], B nibble[idx], carry register.
  - The adder's out[3:0] is written to sum nibble[idx], and out[4] is written to the carry register.
  - idx increments.
  - When idx == NIBBLES-1, next state is DONE.
- DONE: out_valid=1. sum and cout (= carry register) are stable until the handshake.
  - `out_ready` with no new accept: next state is IDLE.
  - `out_ready` with a simultaneous accept: next state is RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W+1). No overflow flag.
- in_valid in RUN is ignored (in_ready=0). Operand inputs are sampled only on the accept edge; later changes to a and b have no effect.
- out_ready outside DONE is ignored.
- ena low: no state, index, carry, or sum update. Handshakes do not complete even if valid and ready are both high.
- rst_n asserted at any time, including mid-RUN:
  - Immediately resets to IDLE; the in-flight operation is lost.
  - idx=0, carry=0, sum=0.
  - out_valid=0, busy=0, in_ready=1 while in IDLE after release.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- Accept at edge E0. RUN occupies edges E1..E(NIBBLES). out_valid is high after edge E(NIBBLES). Latency is NIBBLES cycles from accept to result, with ena held high.
- Throughput with out_ready tied high: one result per NIBBLES+1 cycles.
- All outputs are registered or derived from state only. There is no combinational path from a, b, cin, or in_valid to any output. The single exception is that in_ready depends combinationally on out_ready.
- The adder path is fully combinational within one cycle. There is no internal pipelining of the 4-bit adder.

## Structure
- Shared package `bk_pkg`:
  - state enum {IDLE, RUN, DONE};
  - localparam NIBBLE_W=4;
  - function for the index width, $clog2(NIBBLES) with a minimum of 1.
- One sub-module: the existing `brent_kung_cin`, instantiated once with inputs A nibble, B nibble, and carry register. No new sub-modules.
- Operand shift registers are acceptable in place of indexed selection. Shifting right by 4 each RUN cycle is an implementation choice.

## Test plan
- Carry ripple: NIBBLES=4, a=0xFFFF, b=0x0001, cin=0 → after 4 RUN cycles, sum=0x0000, cout=1, out_valid high.
- Cin chaining: a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0.
- Back-to-back with out_ready high: issue 0x00FF+0x0001, then 0x8000+0x8000 on the DONE cycle.
  - Results are 0x0100/0, then 0x0000/1.
  - No idle cycle occurs between the two operations.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid high → sum stays stable, in_ready stays 0, and no second accept occurs until out_ready=1.
- ena stall: deassert ena for 3 cycles mid-RUN (after nibble 1) → the result is the same as the unstalled case, and latency increases by exactly 3 cycles.
- Reset mid-RUN: pulse rst_n low after 2 RUN cycles → outputs go to the reset values asynchronously. A following 0x0001+0x0001 returns 0x0002/0.
